// File: rtl/bin_map_scanner.sv
// Raster scanner for the bin-label BRAM: accumulates per-bin pixel count and bounding box.
// Optional BIN_MAP_CLEAR_ON_READ_EN adds a write port that zeroes each pixel once it is read.
module bin_map_scanner #(
    parameter int unsigned WIDTH    = 640,
    parameter int unsigned HEIGHT   = 480,
    parameter int unsigned READ_LAT = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  num_bins,
    output logic [18:0] addr,
    input  logic [2:0]  bin_data,
    output logic        busy,
    output logic        done,
    input  logic [2:0]  bin_sel,
    output logic [18:0] res_count,
    output logic [9:0]  res_xmin,
    output logic [9:0]  res_xmax,
    output logic [8:0]  res_ymin,
    output logic [8:0]  res_ymax,
`ifdef BIN_MAP_CLEAR_ON_READ_EN
    output logic [18:0] wr_addr,
    output logic        wr_we,
    output logic [2:0]  wr_data,
`endif
    output logic        res_valid
);

    typedef enum logic [2:0] {StIdle, StInit, StScan, StDrain, StDone} state_e;

    localparam logic [9:0] XLast     = 10'(WIDTH - 1);
    localparam logic [8:0] YLast     = 9'(HEIGHT - 1);
    localparam logic [7:0] DrainLast = 8'(READ_LAT - 1);

    state_e      state_q, state_d;
    logic [2:0]  nb_q;
    logic [18:0] addr_q;
    logic [9:0]  x_q;
    logic [8:0]  y_q;
    logic [7:0]  drain_q;
    logic        last_pix;
    logic        issue;

    assign last_pix = (x_q == XLast) && (y_q == YLast);
    assign issue    = (state_q == StScan);
    assign addr     = addr_q;

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            StIdle, StDone: if (start) state_d = StInit;
            StInit:  state_d = StScan;
            StScan:  if (last_pix) state_d = StDrain;
            StDrain: if (drain_q == DrainLast) state_d = StDone;
            default: state_d = StIdle;
        endcase
        busy = (state_q == StInit) || (state_q == StScan) || (state_q == StDrain);
        done = (state_q == StDone);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            nb_q    <= 3'd0;
            addr_q  <= 19'd0;
            x_q     <= 10'd0;
            y_q     <= 9'd0;
            drain_q <= 8'd0;
        end else begin
            if ((state_q == StIdle || state_q == StDone) && start) nb_q <= num_bins;
            if (state_q == StInit) begin
                addr_q <= 19'd0;
                x_q    <= 10'd0;
                y_q    <= 9'd0;
            end else if (state_q == StScan && !last_pix) begin
                addr_q <= addr_q + 19'd1;
                if (x_q == XLast) begin
                    x_q <= 10'd0;
                    y_q <= y_q + 9'd1;
                end else begin
                    x_q <= x_q + 10'd1;
                end
            end
            drain_q <= (state_q == StDrain) ? drain_q + 8'd1 : 8'd0;
        end
    end

    // Coordinates travel alongside each issued address until its data returns.
    logic       pv_q [READ_LAT];
    logic [9:0] px_q [READ_LAT];
    logic [8:0] py_q [READ_LAT];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < READ_LAT; i++) begin
                pv_q[i] <= 1'b0;
                px_q[i] <= 10'd0;
                py_q[i] <= 9'd0;
            end
        end else begin
            pv_q[0] <= issue;
            px_q[0] <= x_q;
            py_q[0] <= y_q;
            for (int i = 1; i < READ_LAT; i++) begin
                pv_q[i] <= pv_q[i-1];
                px_q[i] <= px_q[i-1];
                py_q[i] <= py_q[i-1];
            end
        end
    end

    logic       ret_v;
    logic [9:0] ret_x;
    logic [8:0] ret_y;
    logic       acc;

    assign ret_v = pv_q[READ_LAT-1];
    assign ret_x = px_q[READ_LAT-1];
    assign ret_y = py_q[READ_LAT-1];
    assign acc   = ret_v && (bin_data != 3'd0) && (bin_data <= nb_q);

`ifdef BIN_MAP_CLEAR_ON_READ_EN
    logic [18:0] pa_q [READ_LAT];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < READ_LAT; i++) pa_q[i] <= 19'd0;
        end else begin
            pa_q[0] <= addr_q;
            for (int i = 1; i < READ_LAT; i++) pa_q[i] <= pa_q[i-1];
        end
    end

    assign wr_we   = ret_v && (state_q == StScan || state_q == StDrain);
    assign wr_addr = pa_q[READ_LAT-1];
    assign wr_data = 3'd0;
`endif

    logic [18:0] cnt_q  [1:7];
    logic [9:0]  xmin_q [1:7];
    logic [9:0]  xmax_q [1:7];
    logic [8:0]  ymin_q [1:7];
    logic [8:0]  ymax_q [1:7];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int b = 1; b <= 7; b++) begin
                cnt_q[b]  <= 19'd0;
                xmin_q[b] <= 10'd1023;
                xmax_q[b] <= 10'd0;
                ymin_q[b] <= 9'd511;
                ymax_q[b] <= 9'd0;
            end
        end else if (state_q == StInit) begin
            for (int b = 1; b <= 7; b++) begin
                cnt_q[b]  <= 19'd0;
                xmin_q[b] <= 10'd1023;
                xmax_q[b] <= 10'd0;
                ymin_q[b] <= 9'd511;
                ymax_q[b] <= 9'd0;
            end
        end else if (acc) begin
            cnt_q[bin_data] <= cnt_q[bin_data] + 19'd1;
            if (ret_x < xmin_q[bin_data]) xmin_q[bin_data] <= ret_x;
            if (ret_x > xmax_q[bin_data]) xmax_q[bin_data] <= ret_x;
            if (ret_y < ymin_q[bin_data]) ymin_q[bin_data] <= ret_y;
            if (ret_y > ymax_q[bin_data]) ymax_q[bin_data] <= ret_y;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n || bin_sel == 3'd0) begin
            res_count <= 19'd0;
            res_xmin  <= 10'd0;
            res_xmax  <= 10'd0;
            res_ymin  <= 9'd0;
            res_ymax  <= 9'd0;
            res_valid <= 1'b0;
        end else begin
            res_count <= cnt_q[bin_sel];
            res_xmin  <= xmin_q[bin_sel];
            res_xmax  <= xmax_q[bin_sel];
            res_ymin  <= ymin_q[bin_sel];
            res_ymax  <= ymax_q[bin_sel];
            res_valid <= (cnt_q[bin_sel] != 19'd0);
        end
    end

endmodule

// File: tb/tb_bin_map_scanner.sv
// Self-checking bench for bin_map_scanner on a reduced 16x8 map with a READ_LAT-deep BRAM model.
// Build with BIN_MAP_CLEAR_ON_READ_EN to also exercise the clear-on-read write port.
`timescale 1ns/1ps
module tb_bin_map_scanner;

    localparam int W   = 16;
    localparam int H   = 8;
    localparam int RL  = 2;
    localparam int N   = W * H;
    localparam int AW  = $clog2(N);
    localparam int LAT = N + RL + 3;  // start cycle through first done cycle, inclusive

    typedef struct packed {
        logic [18:0] cnt;
        logic [9:0]  xmin;
        logic [9:0]  xmax;
        logic [8:0]  ymin;
        logic [8:0]  ymax;
        logic        v;
    } res_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  num_bins = 3'd0;
    logic [2:0]  bin_sel = 3'd0;
    logic [2:0]  bin_data;
    logic [18:0] addr;
    logic        busy, done;
    logic [18:0] res_count;
    logic [9:0]  res_xmin, res_xmax;
    logic [8:0]  res_ymin, res_ymax;
    logic        res_valid;
`ifdef BIN_MAP_CLEAR_ON_READ_EN
    logic [18:0] wr_addr;
    logic        wr_we;
    logic [2:0]  wr_data;
`endif

    logic [2:0] mem [N];
    logic [2:0] rd_pipe [RL];
    res_t       exp_q [$];
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    bin_map_scanner #(.WIDTH(W), .HEIGHT(H), .READ_LAT(RL)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .num_bins  (num_bins),
        .addr      (addr),
        .bin_data  (bin_data),
        .busy      (busy),
        .done      (done),
        .bin_sel   (bin_sel),
        .res_count (res_count),
        .res_xmin  (res_xmin),
        .res_xmax  (res_xmax),
        .res_ymin  (res_ymin),
        .res_ymax  (res_ymax),
`ifdef BIN_MAP_CLEAR_ON_READ_EN
        .wr_addr   (wr_addr),
        .wr_we     (wr_we),
        .wr_data   (wr_data),
`endif
        .res_valid (res_valid)
    );

`ifdef BIN_MAP_CLEAR_ON_READ_EN
    // A pixel counts as cleared when its stamp matches the current map fill generation.
    int clr_stamp [N];
    int fill_gen = 1;

    always @(posedge clk) begin
        if (wr_we) clr_stamp[wr_addr[AW-1:0]] <= fill_gen;
    end

    function automatic logic [2:0] eff(input int a);
        return (clr_stamp[a] == fill_gen) ? 3'd0 : mem[a];
    endfunction
`else
    function automatic logic [2:0] eff(input int a);
        return mem[a];
    endfunction
`endif

    always @(posedge clk) begin
        rd_pipe[0] <= eff(int'(addr[AW-1:0]));
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bin_data = rd_pipe[RL-1];

    function automatic res_t model(input int s, input logic [2:0] nb);
        res_t r;
        r = '0;
        if (s == 0) return r;
        r.xmin = 10'd1023;
        r.ymin = 9'd511;
        if (s > int'(nb)) return r;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                if (int'(eff(y * W + x)) == s) begin
                    r.cnt = r.cnt + 19'd1;
                    if (10'(x) < r.xmin) r.xmin = 10'(x);
                    if (10'(x) > r.xmax) r.xmax = 10'(x);
                    if (9'(y) < r.ymin) r.ymin = 9'(y);
                    if (9'(y) > r.ymax) r.ymax = 9'(y);
                end
            end
        end
        r.v = (r.cnt != 19'd0);
        return r;
    endfunction

    task automatic clear_map();
        for (int a = 0; a < N; a++) mem[a] = 3'd0;
`ifdef BIN_MAP_CLEAR_ON_READ_EN
        fill_gen = fill_gen + 1;
`endif
    endtask

    task automatic set_px(input int x, input int y, input logic [2:0] b);
        mem[y * W + x] = b;
    endtask

    // Expectations are queued at start; results are popped as each bin_sel lookup returns.
    task automatic run_scan(input logic [2:0] nb, input bit extra_starts);
        res_t got, e;
        int   cyc;
        int   wr_seen;
        for (int s = 0; s < 8; s++) exp_q.push_back(model(s, nb));
        @(negedge clk);
        start    = 1'b1;
        num_bins = nb;
        @(negedge clk);
        start    = 1'b0;
        num_bins = 3'd7;
        cyc      = 2;
        wr_seen  = 0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL busy_after_start: busy=%b done=%b, expected busy=1 done=0", busy, done);
        end
        while (done !== 1'b1 && cyc < LAT + 50) begin
`ifdef BIN_MAP_CLEAR_ON_READ_EN
            if (wr_we === 1'b1) begin
                checks++;
                if (wr_addr !== 19'(wr_seen) || wr_data !== 3'd0) begin
                    errors++;
                    $display("FAIL wr_seq: wr_addr=%0d wr_data=%0d, expected %0d and 0",
                             wr_addr, wr_data, wr_seen);
                end
                wr_seen++;
            end
`endif
            start = extra_starts && (cyc == 20 || cyc == 60);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        checks++;
        if (cyc !== LAT || done !== 1'b1) begin
            errors++;
            $display("FAIL latency: done=%b after %0d cycles, expected done=1 after %0d",
                     done, cyc, LAT);
        end
`ifdef BIN_MAP_CLEAR_ON_READ_EN
        checks++;
        if (wr_seen !== N) begin
            errors++;
            $display("FAIL wr_count: %0d write pulses, expected %0d", wr_seen, N);
        end
`endif
        for (int s = 0; s < 8; s++) begin
            bin_sel = 3'(s);
            @(negedge clk);
            got.cnt  = res_count;
            got.xmin = res_xmin;
            got.xmax = res_xmax;
            got.ymin = res_ymin;
            got.ymax = res_ymax;
            got.v    = res_valid;
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL result bin%0d: got cnt=%0d x=%0d..%0d y=%0d..%0d v=%0d, expected cnt=%0d x=%0d..%0d y=%0d..%0d v=%0d",
                         s, got.cnt, got.xmin, got.xmax, got.ymin, got.ymax, got.v,
                         e.cnt, e.xmin, e.xmax, e.ymin, e.ymax, e.v);
            end
        end
        bin_sel = 3'd0;
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || addr !== 19'd0) begin
            errors++;
            $display("FAIL %s ctrl: busy=%b done=%b addr=%0d, expected 0 0 0", tag, busy, done, addr);
        end
        checks++;
        if (res_count !== 19'd0 || res_xmin !== 10'd0 || res_xmax !== 10'd0 ||
            res_ymin !== 9'd0 || res_ymax !== 9'd0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s results: cnt=%0d x=%0d..%0d y=%0d..%0d v=%0d, expected all 0", tag,
                     res_count, res_xmin, res_xmax, res_ymin, res_ymax, res_valid);
        end
    endtask

    task automatic test_reset();
        bin_sel = 3'd3;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        bin_sel = 3'd0;
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("idle");
    endtask

    task automatic test_empty_map();
        clear_map();
        run_scan(3'd7, 1'b0);
    endtask

    task automatic test_single_pixel();
        clear_map();
        set_px(5, 3, 3'd3);
        run_scan(3'd7, 1'b0);
    endtask

    task automatic test_rect_last_pixel();
        clear_map();
        for (int y = 1; y <= 5; y++)
            for (int x = 2; x <= 6; x++) set_px(x, y, 3'd2);
        set_px(W - 1, H - 1, 3'd1);
        run_scan(3'd7, 1'b0);
    endtask

    task automatic test_num_bins();
        clear_map();
        set_px(7, 4, 3'd6);
        set_px(8, 4, 3'd6);
        set_px(0, 0, 3'd1);
        set_px(9, 2, 3'd7);
        run_scan(3'd5, 1'b0);
`ifdef BIN_MAP_CLEAR_ON_READ_EN
        clear_map();
        set_px(7, 4, 3'd6);
        set_px(8, 4, 3'd6);
        set_px(0, 0, 3'd1);
        set_px(9, 2, 3'd7);
`endif
        run_scan(3'd7, 1'b0);
    endtask

    task automatic test_reset_mid_scan();
        clear_map();
        set_px(3, 2, 3'd4);
        set_px(12, 6, 3'd4);
        set_px(1, 0, 3'd5);
        bin_sel = 3'd5;
        @(negedge clk);
        start    = 1'b1;
        num_bins = 3'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        bin_sel = 3'd0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run_scan(3'd7, 1'b1);
    endtask

`ifdef BIN_MAP_CLEAR_ON_READ_EN
    task automatic test_clear_on_read();
        clear_map();
        set_px(4, 4, 3'd2);
        set_px(10, 1, 3'd7);
        run_scan(3'd7, 1'b0);
        run_scan(3'd7, 1'b0);
    endtask
`endif

    initial begin
        clear_map();
        test_reset();
        test_empty_map();
        test_single_pixel();
        test_rect_last_pixel();
        test_num_bins();
        test_reset_mid_scan();
`ifdef BIN_MAP_CLEAR_ON_READ_EN
        test_clear_on_read();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bin_map_scanner.md
Name: bin_map_scanner

Overview:
- Reader for the bin-label BRAM filled by the contour tracer, which writes 3-bit bin IDs into a 640x480 map.
- On a start pulse, scans the whole map in raster order and accumulates per-bin statistics: pixel count and bounding box.
- Results are exposed through a bin-select lookup port for the downstream wing-overlay and sprite logic.
- Bin 0 means "no label" and is never accumulated.

Parameters:
- WIDTH, 640, pixels per row; address = y*WIDTH + x.
- HEIGHT, 480, rows per frame.
- READ_LAT, 2, BRAM read latency in cycles from addr to bin_data.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; begins a scan when idle or done
- num_bins  input  3  highest bin ID accepted; sampled at start
- addr  output  19  bin BRAM read address
- bin_data  input  3  bin BRAM read data, valid READ_LAT cycles after addr
- busy  output  1  high from the cycle after an accepted start until done rises
- done  output  1  high from scan completion until the next accepted start
- bin_sel  input  3  bin whose results are requested
- res_count  output  19  pixel count of bin_sel
- res_xmin  output  10  min x of bin_sel
- res_xmax  output  10  max x of bin_sel
- res_ymin  output  9  min y of bin_sel
- res_ymax  output  9  max y of bin_sel
- res_valid  output  1  res_count != 0

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-low.
- Reset values: state IDLE, addr 0, busy 0, done 0, all result outputs 0. Per-bin stats set to count 0, xmin 1023, ymin 511, xmax 0, ymax 0.
- FSM: IDLE -> INIT -> SCAN -> DRAIN -> DONE.
  - IDLE or DONE + start: latch num_bins, clear done, go to INIT. start in any other state is ignored.
  - INIT (1 cycle): reset all 7 stat sets (bins 1..7) to their reset values; set addr=0, x=0, y=0; busy=1.
  - SCAN: issue one address per cycle.
    - Advance x by 1; at x==WIDTH-1, wrap x to 0 and increment y.
    - addr increments by 1 per cycle; no multiplier.
    - After issuing address WIDTH*HEIGHT-1 (x=639, y=479), go to DRAIN.
  - DRAIN: wait READ_LAT cycles for the last returns, then go to DONE.
  - DONE: busy=0, done=1; hold until start.
- Pipeline alignment: a valid/x/y shift register of depth READ_LAT accompanies each issued address. Each returning bin_data is paired with exactly the coordinates of the address that produced it.
- Accumulate when returning valid && bin_data != 0 && bin_data <= latched num_bins. For bin b = bin_data:
  - count[b] += 1
  - xmin[b] = min(xmin[b], x); xmax[b] = max(xmax[b], x)
  - ymin[b] = min(ymin[b], y); ymax[b] = max(ymax[b], y)
- bin_data outside 1..num_bins is silently dropped.
- Widths: count is 19 bits; the maximum of 307200 fits, so there is no saturation.
- Total latency: start to done = 1 + 1 + WIDTH*HEIGHT + READ_LAT + 1 cycles (307205 at defaults).
- Result port:
  - Registered 1-cycle lookup of bin_sel, live in every state.
  - Stats read during a scan show partial values; only values read while done=1 are final.
  - bin_sel=0 returns all zeros, with res_valid=0.
  - An empty bin returns count 0, xmin 1023, ymin 511, xmax 0, ymax 0, res_valid 0.
- Reset mid-scan: immediate return to IDLE with all outputs and stats at reset values. In-flight BRAM returns are discarded.
- start arriving in the same cycle the FSM enters DONE is ignored; it must be reasserted.

Optional Feature:
- Macro: BIN_MAP_CLEAR_ON_READ_EN.
- Defined: adds ports wr_addr (output, 19), wr_we (output, 1), wr_data (output, 3, constant 0).
  - For every returning pixel in SCAN/DRAIN, drive wr_we=1 with wr_addr equal to that pixel's address, delayed with the pipeline. This zeroes the map through the second BRAM port so the next tracer pass starts clean.
  - wr_we is 0 outside SCAN/DRAIN and during reset.
- Undefined: the ports are absent and the map is read-only.

Test Plan:
- All-zero map, num_bins=7, start -> done after 307205 cycles; every bin_sel gives res_valid=0, count 0, xmin 1023.
- Single pixel bin 3 at (x=100, y=50) -> bin_sel=3: count 1, xmin=xmax=100, ymin=ymax=50, valid 1; bins 1,2,4..7 invalid.
- Bin 2 filled over rectangle x 10..19, y 200..204 -> count 50, box (10,19,200,204). Also put a pixel at (639,479) for bin 1 -> bin 1 box (639,639,479,479), checking last-pixel drain.
- Map containing bin 6 pixels with num_bins=5 -> bin 6 count 0; a second start with num_bins=7 -> bin 6 counted, and stats from the prior scan are cleared.
- Pulse reset_n low at cycle 1000 of a scan -> busy=0, done=0, addr=0, all results zero. A new start then completes normally. Extra start pulses mid-scan do not restart the scan or change the completion cycle.
- With BIN_MAP_CLEAR_ON_READ_EN defined: after one scan, wr_we has pulsed 307200 times with wr_addr 0..307199 in order. A second scan on the BRAM model reports all bins invalid.
